// File: rtl/init_seq.sv
// ----------------------------------------------------------------------------
// init_seq
//
// Power-up baud-rate initialisation sequencer for CH_NUM UART channels.
// After the PLL reports lock, the block waits WAIT_LEN settle cycles, then
// walks the channels in order. For each channel it loads that channel's baud
// word and fires a one-cycle latch strobe, followed by a gap before the next
// channel. When every channel has been latched it sits in DONE until lock
// is lost, a new lock edge arrives, or a reinit request is made in DONE.
//
// Optional feature (macro INIT_SEQ_ACK_EN):
//   When defined, each gap ends early on ack[ch], or after ACK_TO cycles
//   without an ack, which sets the sticky err[ch] flag. When undefined, ack
//   is ignored, err is tied low and every gap is GAP_LEN cycles long.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   locked     in   PLL lock indication (synchronous to clk)
//   reinit     in   one-cycle request to rerun the sequence (honoured in DONE)
//   baud_cfg   in   per-channel baud words, channel i at [i*BAUD_W +: BAUD_W]
//   ack        in   per-channel latch acknowledge (INIT_SEQ_ACK_EN only)
//   latch_baud out  one-hot single-cycle latch strobes
//   baud_word  out  registered baud words, same packing as baud_cfg
//   busy       out  high in WAIT, LATCH and GAP
//   done       out  high while in DONE
//   err        out  per-channel sticky ack-timeout flags
// ----------------------------------------------------------------------------
module init_seq #(
    parameter int CH_NUM   = 2,
    parameter int BAUD_W   = 16,
    parameter int WAIT_LEN = 32728,
    parameter int GAP_LEN  = 16,
    parameter int ACK_TO   = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       locked,
    input  logic                       reinit,
    input  logic [CH_NUM*BAUD_W-1:0]   baud_cfg,
    input  logic [CH_NUM-1:0]          ack,
    output logic [CH_NUM-1:0]          latch_baud,
    output logic [CH_NUM*BAUD_W-1:0]   baud_word,
    output logic                       busy,
    output logic                       done,
    output logic [CH_NUM-1:0]          err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LATCH,
        GAP,
        DONE
    } state_t;

    localparam logic [15:0]       WAIT_LAST = 16'(WAIT_LEN - 1);
    localparam logic [2:0]        CH_LAST   = 3'(CH_NUM - 1);
    localparam logic [CH_NUM-1:0] CH_ONE    = CH_NUM'(1);

    state_t              state;
    logic [15:0]         cnt;
    logic [2:0]          ch;
    logic                locked_r;

    logic [2:0]          ch_nxt;
    logic [2:0]          lat_ch;
    logic [CH_NUM-1:0]   lat_mask;
    logic [CH_NUM-1:0]   ch_mask;
    logic                gap_end;

    // The channel about to be latched: channel 0 when leaving WAIT,
    // the next channel when leaving a gap.
    assign ch_nxt   = ch + 3'd1;
    assign lat_ch   = (state == GAP) ? ch_nxt : 3'd0;
    assign lat_mask = CH_ONE << lat_ch;
    assign ch_mask  = CH_ONE << ch;

`ifdef INIT_SEQ_ACK_EN
    localparam logic [15:0] ACK_LAST = 16'(ACK_TO - 1);

    logic [CH_NUM-1:0] err_q;
    logic              ack_hit;
    logic              ack_timeout;
    logic [15:0]       unused_gap_len;

    // A gap ends on the current channel's ack, or on timeout when no ack
    // has arrived within ACK_TO cycles.
    assign ack_hit        = |(ack & ch_mask);
    assign ack_timeout    = !ack_hit && (cnt == ACK_LAST);
    assign gap_end        = ack_hit || (cnt == ACK_LAST);
    assign err            = err_q;
    assign unused_gap_len = 16'(GAP_LEN);
`else
    localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

    logic [CH_NUM-1:0] unused_ack;
    logic [15:0]       unused_ack_to;

    assign gap_end       = (cnt == GAP_LAST);
    assign err           = '0;
    assign unused_ack    = ack;
    assign unused_ack_to = 16'(ACK_TO);
`endif

    // Sequencer. Lock loss wins over everything, then a fresh lock edge or
    // a reinit in DONE restarts the sequence; otherwise the state walks
    // WAIT -> (LATCH -> GAP) per channel -> DONE. latch_baud defaults to 0
    // every cycle so each strobe lasts exactly one cycle. The baud word is
    // loaded on the same edge that enters LATCH so it is valid with the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ch         <= '0;
            locked_r   <= 1'b0;
            latch_baud <= '0;
            baud_word  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef INIT_SEQ_ACK_EN
            err_q      <= '0;
`endif
        end else begin
            locked_r   <= locked;
            latch_baud <= '0;
            if (!locked) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (!locked_r || (state == DONE && reinit)) begin
                state <= WAIT;
                cnt   <= '0;
                ch    <= '0;
                busy  <= 1'b1;
                done  <= 1'b0;
`ifdef INIT_SEQ_ACK_EN
                err_q <= '0;
`endif
            end else begin
                case (state)
                    WAIT: begin
                        if (cnt == WAIT_LAST) begin
                            state      <= LATCH;
                            cnt        <= '0;
                            latch_baud <= lat_mask;
                            for (int i = 0; i < CH_NUM; i++) begin
                                if (lat_mask[i]) begin
                                    baud_word[i*BAUD_W +: BAUD_W] <= baud_cfg[i*BAUD_W +: BAUD_W];
                                end
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    LATCH: begin
                        state <= GAP;
                        cnt   <= '0;
                    end
                    GAP: begin
                        if (gap_end) begin
                            cnt <= '0;
`ifdef INIT_SEQ_ACK_EN
                            if (ack_timeout) begin
                                err_q <= err_q | ch_mask;
                            end
`endif
                            if (ch == CH_LAST) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state      <= LATCH;
                                ch         <= ch_nxt;
                                latch_baud <= lat_mask;
                                for (int i = 0; i < CH_NUM; i++) begin
                                    if (lat_mask[i]) begin
                                        baud_word[i*BAUD_W +: BAUD_W] <= baud_cfg[i*BAUD_W +: BAUD_W];
                                    end
                                end
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        // IDLE waits for a lock edge, DONE for reinit.
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/init_seq.md
INIT_SEQ -- requirements
Module: init_seq

Interface
REQ-001 SHALL have parameter CH_NUM, default 2: number of UART channels to initialise, range 1..8.
REQ-002 SHALL have parameter BAUD_W, default 16: width of one baud word.
REQ-003 SHALL have parameter WAIT_LEN, default 32728: settle cycles after lock, range 1..65535.
REQ-004 SHALL have parameter GAP_LEN, default 16: cycles between channel latches, range 1..65535.
REQ-005 SHALL have parameter ACK_TO, default 1024: ack timeout cycles, range 1..65535.
REQ-006 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port locked, input, 1: PLL lock indication, synchronous to clk.
REQ-009 SHALL have port reinit, input, 1: one-cycle request to rerun the sequence.
REQ-010 SHALL have port baud_cfg, input, CH_NUM*BAUD_W: per-channel baud words; channel i in bits [i*BAUD_W +: BAUD_W].
REQ-011 SHALL have port ack, input, CH_NUM: per-channel latch acknowledge from the UART.
REQ-012 SHALL have port latch_baud, output, CH_NUM: one-hot single-cycle latch strobes.
REQ-013 SHALL have port baud_word, output, CH_NUM*BAUD_W: registered per-channel baud words, same packing as baud_cfg.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE and DONE.
REQ-015 SHALL have port done, output, 1: high while in DONE.
REQ-016 SHALL have port err, output, CH_NUM: per-channel sticky ack-timeout flags.

Function
REQ-017 SHALL implement states IDLE, WAIT, LATCH, GAP, DONE, a 16-bit cycle counter cnt, and a channel index ch.
REQ-018 SHALL register locked into locked_r; a rising edge (locked=1, locked_r=0) in any state SHALL enter WAIT with cnt=0, ch=0, err cleared.
REQ-019 SHALL, when locked=0 in any non-IDLE state, enter IDLE next cycle, clearing done, busy and latch_baud; baud_word SHALL hold; lock loss has priority over all other events.
REQ-020 SHALL remain in WAIT for exactly WAIT_LEN cycles, then enter LATCH.
REQ-021 SHALL, in LATCH (exactly one cycle), drive latch_baud[ch]=1 with all other bits 0, and load baud_word slice ch from baud_cfg slice ch on the edge entering LATCH, so the new word is valid during the strobe.
REQ-022 SHALL, in GAP, restart cnt at 0 and stay GAP_LEN cycles; then enter DONE if ch==CH_NUM-1, else increment ch and enter LATCH.
REQ-023 SHALL, in DONE, hold done=1 until lock loss, reinit, or a lock rising edge.
REQ-024 SHALL act on reinit only in DONE (enter WAIT, cnt=0, ch=0, err cleared, done=0 next cycle); reinit in other states SHALL be ignored.
REQ-025 SHALL never wrap cnt; it resets on every state entry.
REQ-026 SHALL with CH_NUM=1 perform one LATCH and one GAP, then DONE.

Reset
REQ-027 SHALL on rst=0 asynchronously force state IDLE, cnt=0, ch=0, locked_r=0, latch_baud=0, baud_word=0, busy=0, done=0, err=0.
REQ-028 SHALL, if locked is already 1 at reset release, treat the first sampled cycle as a lock rising edge and start the sequence.

Configuration
REQ-029 SHALL with macro INIT_SEQ_ACK_EN defined: GAP exits when ack[ch]=1 (sampled only in GAP) or after ACK_TO cycles, the latter setting err[ch]=1; the next step is as in REQ-022.
REQ-030 SHALL without INIT_SEQ_ACK_EN: ack ignored, err tied to 0, GAP timing per REQ-022.

Verification (CH_NUM=2, WAIT_LEN=100, GAP_LEN=4, ACK_TO=8, baud_cfg=0x0364_01B2)
REQ-031 SHALL check: locked rises at cycle 0 -> latch_baud=01 at cycle 101 with baud_word[15:0]=0x01B2, latch_baud=10 at cycle 106 with baud_word[31:16]=0x0364, done=1 from cycle 111.
REQ-032 SHALL check: locked drops during WAIT -> IDLE next cycle, no strobe, done=0; relock -> full 100-cycle wait restarts.
REQ-033 SHALL check: reinit in DONE -> done=0 next cycle, both strobes repeat with the same spacing; reinit pulsed during WAIT -> ignored, timing unchanged.
REQ-034 SHALL check: rst asserted mid-GAP -> all outputs 0 immediately; locked held 1 at release -> sequence restarts per REQ-028.
REQ-035 SHALL check with INIT_SEQ_ACK_EN: ack[0] 2 cycles after strobe, ack[1] never -> second strobe 3 cycles after the first, err=10 after 8 GAP cycles, done=1.
